// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32x32 multiply / divide unit with HI/LO registers.
// One radix-2 step per cycle: shift-add multiply, restoring divide.
// Optional macro MDU_SIGNED_EN enables signed MULT/DIV. Without it, op[0] is
// ignored and the signed opcodes run as their unsigned forms.
module mult_div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic        wrHi,
    input  logic        wrLo,
    input  logic [31:0] writeData,
    output logic        busy,
    output logic        done,
    output logic        divZero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d;            // multiplicand or divisor magnitude
    logic [63:0] acc_q, acc_d;        // {partial hi, multiplier} or {remainder, quotient}
    logic        is_div_q, is_div_d;
    logic        neg_lo_q, neg_lo_d;  // product sign (mul) / quotient sign (div)
    logic        neg_hi_q, neg_hi_d;  // remainder sign (div only)
    logic        dz_q, dz_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        sgn_op;
`ifdef MDU_SIGNED_EN
    assign sgn_op = op[0];
`else
    logic unused_op0;
    assign unused_op0 = op[0];
    assign sgn_op     = 1'b0;
`endif

    // Operand magnitudes taken at the start edge
    logic        neg1, neg2;
    logic [31:0] mag1, mag2;
    assign neg1 = sgn_op & in1[31];
    assign neg2 = sgn_op & in2[31];
    assign mag1 = neg1 ? (32'd0 - in1) : in1;
    assign mag2 = neg2 ? (32'd0 - in2) : in2;

    // Single iteration of each algorithm, plus the sign-fixed final result
    logic [32:0] mul_sum, div_shift, div_diff;
    logic [63:0] mul_next, div_next, iter, prod;
    logic [31:0] fin_hi, fin_lo;
    always_comb begin
        mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, a_q} : 33'd0);
        mul_next  = {mul_sum, acc_q[31:1]};
        div_shift = acc_q[63:31];
        div_diff  = div_shift - {1'b0, a_q};
        div_next  = div_diff[32] ? {div_shift[31:0], acc_q[30:0], 1'b0}
                                 : {div_diff[31:0],  acc_q[30:0], 1'b1};
        iter      = is_div_q ? div_next : mul_next;
        prod      = neg_lo_q ? (64'd0 - iter) : iter;
        if (is_div_q) begin
            fin_lo = neg_lo_q ? (32'd0 - iter[31:0])  : iter[31:0];
            fin_hi = neg_hi_q ? (32'd0 - iter[63:32]) : iter[63:32];
        end else begin
            fin_lo = prod[31:0];
            fin_hi = prod[63:32];
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        acc_d    = acc_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    dz_d     = 1'b0;
                    cnt_d    = 6'd32;
                    is_div_d = op[1];
                    neg_lo_d = neg1 ^ neg2;
                    if (op[1]) begin
                        a_d      = mag2;
                        acc_d    = {32'd0, mag1};
                        neg_hi_d = neg1;
                    end else begin
                        a_d      = mag1;
                        acc_d    = {32'd0, mag2};
                        neg_hi_d = 1'b0;
                    end
                    // Zero divisor skips the iterations and leaves HI/LO alone
                    if (op[1] && (in2 == 32'd0)) begin
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    if (wrHi) hi_d = writeData;
                    if (wrLo) lo_d = writeData;
                end
            end
            RUN: begin
                acc_d = iter;
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd1) begin
                    hi_d    = fin_hi;
                    lo_d    = fin_lo;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 6'd0;
            a_q      <= 32'd0;
            acc_q    <= 64'd0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            acc_q    <= acc_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign divZero = dz_q;
    assign hi      = hi_q;
    assign lo      = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit (follows MDU_SIGNED_EN).
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] in1 = 32'd0;
    logic [31:0] in2 = 32'd0;
    logic        wrHi = 1'b0;
    logic        wrLo = 1'b0;
    logic [31:0] writeData = 32'd0;
    logic        busy, done, divZero;
    logic [31:0] hi, lo;

    int errs = 0;
    int checks = 0;

    mult_div_unit dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .in1(in1), .in2(in2),
        .wrHi(wrHi), .wrLo(wrLo), .writeData(writeData),
        .busy(busy), .done(done), .divZero(divZero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Counts edges after the start edge until done is seen (bounded)
    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
    endtask

    // Issue one op, scramble inputs while running, check latency and result
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat,
                          input logic [31:0] ehi, input logic [31:0] elo);
        int n;
        op = o; in1 = a; in2 = b; start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, " busy"}, busy, 1'b1);
        in1 = $urandom; in2 = $urandom; op = 2'($urandom);
        wait_done(n);
        chk({tag, " lat"}, n, exp_lat);
        chk({tag, " hi"}, hi, ehi);
        chk({tag, " lo"}, lo, elo);
        tick();
        chk({tag, " done end"}, done, 1'b0);
        chk({tag, " idle"}, busy, 1'b0);
    endtask

    initial begin
        int n, ndone;
        #2;
        chk("rst busy", busy, 1'b0);
        chk("rst done", done, 1'b0);
        chk("rst dz", divZero, 1'b0);
        chk("rst hilo", {hi, lo}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick();

        run_op("multu max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32, 32'hFFFFFFFE, 32'h00000001);
`ifdef MDU_SIGNED_EN
        run_op("mult neg", 2'b01, 32'hFFFFFFFD, 32'd7, 32, 32'hFFFFFFFF, 32'hFFFFFFEB);
        run_op("div neg", 2'b11, 32'hFFFFFFF9, 32'd2, 32, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div ovf", 2'b11, 32'h80000000, 32'hFFFFFFFF, 32, 32'h00000000, 32'h80000000);
`else
        run_op("mult neg", 2'b01, 32'hFFFFFFFD, 32'd7, 32, 32'h00000006, 32'hFFFFFFEB);
        run_op("div neg", 2'b11, 32'hFFFFFFF9, 32'd2, 32, 32'h00000001, 32'h7FFFFFFC);
        run_op("div ovf", 2'b11, 32'h80000000, 32'hFFFFFFFF, 32, 32'h80000000, 32'h00000000);
`endif
        run_op("divu 100/7", 2'b10, 32'd100, 32'd7, 32, 32'd2, 32'd14);

        // Preload HI/LO, then divide by zero
        writeData = 32'h12345678; wrHi = 1'b1; wrLo = 1'b1;
        tick();
        wrHi = 1'b0; wrLo = 1'b0;
        chk("mt hilo", {hi, lo}, {32'h12345678, 32'h12345678});
        run_op("divu zero", 2'b10, 32'd5, 32'd0, 0, 32'h12345678, 32'h12345678);
        chk("dz held", divZero, 1'b1);

        // Reset in the middle of a multiply
        op = 2'b00; in1 = 32'd3; in2 = 32'd5; start = 1'b1;
        tick();
        start = 1'b0;
        chk("dz cleared", divZero, 1'b0);
        repeat (9) tick();
        rst = 1'b1;
        #1;
        chk("midrst busy", busy, 1'b0);
        chk("midrst hilo", {hi, lo}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) ndone++;
        end
        chk("midrst no done", ndone, 0);
        chk("midrst hilo after", {hi, lo}, 64'd0);

        // start and wrHi while busy are ignored
        op = 2'b10; in1 = 32'd1000; in2 = 32'd10; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        op = 2'b00; in1 = 32'd3; in2 = 32'd4; start = 1'b1;
        tick();
        start = 1'b0;
        writeData = 32'hA5A5A5A5; wrHi = 1'b1;
        tick();
        wrHi = 1'b0;
        wait_done(n);
        chk("busy ign lat", n, 26);
        chk("busy ign hi", hi, 32'd0);
        chk("busy ign lo", lo, 32'd100);
        tick();
        wrHi = 1'b1;
        tick();
        wrHi = 1'b0;
        chk("mthi idle", hi, 32'hA5A5A5A5);
        chk("mthi keeps lo", lo, 32'd100);

        // start wins over wrLo in the same cycle
        op = 2'b00; in1 = 32'd2; in2 = 32'd3; start = 1'b1;
        writeData = 32'h0000DEAD; wrLo = 1'b1;
        tick();
        start = 1'b0; wrLo = 1'b0;
        wait_done(n);
        chk("start wins lat", n, 32);
        chk("start wins res", {hi, lo}, {32'd0, 32'd6});
        tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
